// File: rtl/jpeg_pkg.sv
// Shared constants and FSM state type for the JPEG entropy-coded-segment packer.
package jpeg_pkg;

   localparam logic [7:0] JPEG_MARKER_PFX = 8'hFF;
   localparam logic [7:0] JPEG_STUFF      = 8'h00;
   localparam logic [7:0] JPEG_EOI        = 8'hD9;
   localparam logic       PAD_BIT         = 1'b1;

   typedef enum logic [2:0] {RUN, DRAIN, PAD, FLUSH, EOI1, EOI2} packer_state_t;

   // Keep the n leading valid bits of top, fill the rest of the byte with pad bits.
   function automatic logic [7:0] pad_byte(input logic [7:0] top, input logic [3:0] n);
      logic [7:0] fill;
      fill = {8{PAD_BIT}} >> n;
      return (top & ~fill) | fill;
   endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with 0xFF->0x00 stuffing and valid/ready hold; reloads in the cycle it drains.
module jpeg_byte_stuffer
   import jpeg_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ld_valid,
   input  logic [7:0] i_ld_byte,
   input  logic       i_ld_raw,
   output logic       o_ld_ready,
   output logic       o_stuff_pend,
   output logic       o_empty,
   output logic [7:0] o_out_byte,
   output logic       o_out_valid,
   input  logic       i_out_ready
);

   logic [7:0] r_byte;
   logic       r_valid;
   logic       r_pend;
   logic       w_free;

   assign w_free       = !r_valid || i_out_ready;
   assign o_ld_ready   = w_free && !r_pend;
   assign o_stuff_pend = r_pend;
   assign o_empty      = !r_valid && !r_pend;
   assign o_out_byte   = r_byte;
   assign o_out_valid  = r_valid;

   // A pending stuff byte always wins over a new load; raw loads carry markers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte  <= 8'h00;
         r_valid <= 1'b0;
         r_pend  <= 1'b0;
      end else if (w_free) begin
         if (r_pend) begin
            r_byte  <= JPEG_STUFF;
            r_valid <= 1'b1;
            r_pend  <= 1'b0;
         end else if (i_ld_valid) begin
            r_byte  <= i_ld_byte;
            r_valid <= 1'b1;
            r_pend  <= !i_ld_raw && (i_ld_byte == JPEG_MARKER_PFX);
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs {Huffman code, amplitude} words MSB-first into stuffed bytes, 1s-pads the block tail.
// Optional EOI_MARKER_EN appends an unstuffed FF,D9 marker before block_done.
module jpeg_bitstream_packer
   import jpeg_pkg::*;
#(
   parameter int ACC_W  = 32,
   parameter int MAX_IN = 23
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [15:0] i_huff_code,
   input  logic [3:0]  i_huff_len,
   input  logic [7:0]  i_val_bits,
   input  logic [3:0]  i_val_len,
   input  logic        i_in_last,
   output logic [7:0]  o_out_byte,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic        o_block_done
);

   localparam int            CW       = $clog2(ACC_W + 1);
   localparam logic [CW-1:0] FILL_MAX = CW'(ACC_W - MAX_IN);

   packer_state_t    r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_live;
   logic             r_block_done;
`ifdef EOI_MARKER_EN
   logic             r_eoi_sent;
`endif

   logic [3:0]       w_vlen;
   logic [15:0]      w_code_m;
   logic [7:0]       w_val_m;
   logic [23:0]      w_word24;
   logic [ACC_W-1:0] w_word;
   logic [ACC_W-1:0] w_acc_sh;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CW-1:0]    w_wlen;
   logic [CW-1:0]    w_cnt_mid;
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW-1:0]    w_shamt;
   logic             w_accept;
   logic             w_has_byte;
   logic             w_pop;
   logic             w_ld_valid;
   logic             w_ld_raw;
   logic [7:0]       w_ld_byte;
   logic             w_ld_ready;
   logic             w_stuff_pend;
   logic             w_empty;

   assign w_vlen   = (i_val_len > 4'd8) ? 4'd8 : i_val_len;
   assign w_code_m = i_huff_code & ((16'h1 << i_huff_len) - 16'h1);
   assign w_val_m  = i_val_bits & 8'((9'h1 << w_vlen) - 9'h1);
   assign w_word24 = ({8'h00, w_code_m} << w_vlen) | {16'h0000, w_val_m};
   assign w_word   = ACC_W'(w_word24);
   assign w_wlen   = CW'(i_huff_len) + CW'(w_vlen);

   // r_live keeps in_ready low for the first cycle out of reset.
   assign o_in_ready   = r_live && (r_state == RUN) && (r_bit_cnt <= FILL_MAX);
   assign w_accept     = i_in_valid && o_in_ready;
   assign w_has_byte   = (r_bit_cnt >= CW'(8));
   assign w_pop        = ((r_state == RUN) || (r_state == DRAIN)) && w_has_byte && w_ld_ready;
   assign o_block_done = r_block_done;

   // Pop first, then append the new word directly below the surviving bits.
   assign w_acc_sh  = w_pop ? (r_acc << 8) : r_acc;
   assign w_cnt_mid = w_pop ? (r_bit_cnt - CW'(8)) : r_bit_cnt;
   assign w_shamt   = CW'(ACC_W) - w_cnt_mid - w_wlen;
   assign w_acc_nxt = w_accept ? (w_acc_sh | (w_word << w_shamt)) : w_acc_sh;
   assign w_cnt_nxt = w_accept ? (w_cnt_mid + w_wlen) : w_cnt_mid;

   always_comb begin
      w_ld_valid = 1'b0;
      w_ld_raw   = 1'b0;
      w_ld_byte  = r_acc[ACC_W-1 -: 8];
      case (r_state)
         RUN, DRAIN: w_ld_valid = w_has_byte;
         PAD: begin
            w_ld_valid = 1'b1;
            w_ld_byte  = pad_byte(r_acc[ACC_W-1 -: 8], r_bit_cnt[3:0]);
         end
         EOI1: begin
            w_ld_valid = 1'b1;
            w_ld_raw   = 1'b1;
            w_ld_byte  = JPEG_MARKER_PFX;
         end
         EOI2: begin
            w_ld_valid = 1'b1;
            w_ld_raw   = 1'b1;
            w_ld_byte  = JPEG_EOI;
         end
         default: w_ld_valid = 1'b0;
      endcase
   end

   jpeg_byte_stuffer u_stuffer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_ld_valid   (w_ld_valid),
      .i_ld_byte    (w_ld_byte),
      .i_ld_raw     (w_ld_raw),
      .o_ld_ready   (w_ld_ready),
      .o_stuff_pend (w_stuff_pend),
      .o_empty      (w_empty),
      .o_out_byte   (o_out_byte),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= RUN;
         r_acc        <= '0;
         r_bit_cnt    <= '0;
         r_live       <= 1'b0;
         r_block_done <= 1'b0;
`ifdef EOI_MARKER_EN
         r_eoi_sent   <= 1'b0;
`endif
      end else begin
         r_live       <= 1'b1;
         r_block_done <= 1'b0;
         case (r_state)
            RUN: begin
               r_acc     <= w_acc_nxt;
               r_bit_cnt <= w_cnt_nxt;
               if (w_accept && i_in_last) r_state <= DRAIN;
            end
            DRAIN: begin
               r_acc     <= w_acc_nxt;
               r_bit_cnt <= w_cnt_nxt;
               if (!w_has_byte && !w_stuff_pend)
                  r_state <= (r_bit_cnt != '0) ? PAD : FLUSH;
            end
            PAD: if (w_ld_ready) begin
               r_acc     <= '0;
               r_bit_cnt <= '0;
               r_state   <= DRAIN;
            end
            FLUSH: if (w_empty) begin
`ifdef EOI_MARKER_EN
               if (r_eoi_sent) begin
                  r_eoi_sent   <= 1'b0;
                  r_block_done <= 1'b1;
                  r_state      <= RUN;
               end else begin
                  r_state <= EOI1;
               end
`else
               r_block_done <= 1'b1;
               r_state      <= RUN;
`endif
            end
            EOI1: if (w_ld_ready) r_state <= EOI2;
            EOI2: if (w_ld_ready) begin
               r_state <= FLUSH;
`ifdef EOI_MARKER_EN
               r_eoi_sent <= 1'b1;
`endif
            end
            default: r_state <= RUN;
         endcase
      end
   end

endmodule
